// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared constants for the register scoreboard
package reg_scoreboard_pkg;

    localparam int NREG = 32;
    localparam int CNT_W = 2;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// rtl/reg_scoreboard_counter.sv - per-register saturating pending-write counter
module sb_counter #(
    parameter int WIDTH = reg_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             nonzero,
    output logic             full,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;

    assign cnt       = cnt_q;
    assign nonzero   = |cnt_q;
    assign full      = &cnt_q;
    // A lone retire against an empty counter; a paired issue cancels it.
    assign underflow = dec && !inc && !nonzero;

    // Counter state: clear wins, a simultaneous inc/dec pair is a no-op, never wraps.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (inc && !dec && !full) begin
            cnt_q <= cnt_q + ONE;
        end else if (dec && !inc && nonzero) begin
            cnt_q <= cnt_q - ONE;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard with issue stall decode
module reg_scoreboard #(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     issue_valid,
    input  logic                                     issue_we,
    input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] issue_waddr,
    input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] rs_addr,
    input  logic                                     rs_used,
    input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] rt_addr,
    input  logic                                     rt_used,
    output logic                                     stall,
    input  logic                                     wb_valid,
    input  logic                                     wb_we,
    input  logic [reg_scoreboard_pkg::REG_ADDR_W-1:0] wb_addr,
    input  logic                                     flush,
    output logic [NREG-1:0]                          pending,
    output logic                                     err
);

    import reg_scoreboard_pkg::*;

    // Entry 0 of these vectors is tied low, so $0 can never stall or count.
    logic [NREG-1:0] nonzero_vec;
    logic [NREG-1:0] full_vec;
    logic [NREG-1:0] cnt_nz_vec;
    logic [NREG-1:1] inc_vec;
    logic [NREG-1:1] dec_vec;
    logic [NREG-1:1] underflow_vec;
    logic            accept;
    logic            retire;

    assign nonzero_vec[0] = 1'b0;
    assign full_vec[0]    = 1'b0;
    assign cnt_nz_vec[0]  = 1'b0;
    assign pending        = cnt_nz_vec;

    // Hazard decode from registered counts only; writeback never bypasses into it.
    always_comb begin
        stall = issue_valid &&
                ((rs_used && nonzero_vec[rs_addr]) ||
                 (rt_used && nonzero_vec[rt_addr]) ||
                 (issue_we && full_vec[issue_waddr]));
    end

    // Accepted issue and retire events; a flush cycle discards both.
    always_comb begin
        accept = issue_valid && !stall && issue_we && (issue_waddr != REG_ZERO) && !flush;
        retire = wb_valid && wb_we && (wb_addr != REG_ZERO) && !flush;
    end

    // One-hot steering of the events onto the per-register counters.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_vec[i] = accept && (issue_waddr == REG_ADDR_W'(i));
            dec_vec[i] = retire && (wb_addr == REG_ADDR_W'(i));
        end
    end

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_w;

        sb_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .clr       (flush),
            .cnt       (cnt_w),
            .nonzero   (nonzero_vec[g]),
            .full      (full_vec[g]),
            .underflow (underflow_vec[g])
        );

        assign cnt_nz_vec[g] = |cnt_w;
    end

    // Sticky underflow flag; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|underflow_vec) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_we, rs_used, rt_used;
    logic [4:0]  issue_waddr, rs_addr, rt_addr, wb_addr;
    logic        wb_valid, wb_we, flush;
    logic        stall, err;
    logic [31:0] pending;

    int total = 0;
    int bad = 0;
    int model_cnt[32];
    bit model_err;

    reg_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_waddr (issue_waddr),
        .rs_addr     (rs_addr),
        .rs_used     (rs_used),
        .rt_addr     (rt_addr),
        .rt_used     (rt_used),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .pending     (pending),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = (model_cnt[i] != 0);
        return v;
    endfunction

    // Drive one cycle of inputs, check stall before the edge, advance the model, check state after.
    task automatic step(input bit rst, input bit fl,
                        input bit iv, input bit we, input int wa,
                        input bit ru, input int ra, input bit tu, input int ta,
                        input bit wv, input bit wwe, input int wba);
        bit exp_stall, acc, ret;
        reset = rst; flush = fl;
        issue_valid = iv; issue_we = we; issue_waddr = 5'(wa);
        rs_used = ru; rs_addr = 5'(ra); rt_used = tu; rt_addr = 5'(ta);
        wb_valid = wv; wb_we = wwe; wb_addr = 5'(wba);
        #1;
        exp_stall = iv && ((ru && ra != 0 && model_cnt[ra] != 0) ||
                           (tu && ta != 0 && model_cnt[ta] != 0) ||
                           (we && wa != 0 && model_cnt[wa] == 3));
        check("stall", {31'b0, stall}, {31'b0, exp_stall});
        @(posedge clk);
        if (rst) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
            model_err = 0;
        end else if (fl) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
        end else begin
            acc = iv && !exp_stall && we && wa != 0;
            ret = wv && wwe && wba != 0;
            if (!(acc && ret && wa == wba)) begin
                if (acc) model_cnt[wa]++;
                if (ret) begin
                    if (model_cnt[wba] == 0) model_err = 1;
                    else model_cnt[wba]--;
                end
            end
        end
        #1;
        check("pending", pending, model_pending());
        check("err", {31'b0, err}, {31'b0, model_err});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (model_cnt[i]) model_cnt[i] = 0;
        model_err = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pending", pending, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);

        // RAW on $8; the retire cycle still stalls, the next does not.
        step(0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        check("pend8", {31'b0, pending[8]}, 32'h1);
        step(0, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 8, 0, 0, 1, 1, 8);
        step(0, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0);

        // $0 is never tracked.
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        check("zero_pending", pending, 32'h0);

        // Saturation on $9: fourth write stalls until one retire.
        for (int k = 0; k < 4; k++) step(0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 9, 0, 0, 0, 0, 1, 1, 9);
        step(0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        check("sat9_stall_again", {31'b0, stall}, 32'h1);

        // Same-cycle accept and retire on $10 cancel.
        step(0, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 10, 0, 0, 0, 0, 1, 1, 10);
        check("pair10", {30'b0, pending[10], err}, 32'h2);

        // Underflow on $11 is sticky through flush, cleared by reset.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 11);
        check("uflow_err", {31'b0, err}, 32'h1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_keeps_err", {31'b0, err}, 32'h1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Flush discards same-cycle issue and retire.
        step(0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 5, 0, 0, 0, 0, 1, 1, 3);
        check("flush_pending", pending, 32'h0);
        idle();

        // Random traffic on a few registers to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 5),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 5),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 5),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard for the pipelined MIPS core. It sits between decode/issue and the general register file. It tracks how many in-flight instructions will still write each architectural register, and it stalls decode when a source operand, or a new destination, conflicts with a pending write. It is the read-side counterpart of the register-file write port: writeback retires each pending write here in the same cycle it commits to the register file.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^CNT_W-1 = 3.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decode has an instruction ready to issue this cycle.
- issue_we  in  1  the issuing instruction writes a register.
- issue_waddr  in  5  destination register of the issuing instruction.
- rs_addr  in  5  first source register.
- rs_used  in  1  first source is actually read.
- rt_addr  in  5  second source register.
- rt_used  in  1  second source is actually read.
- stall  out  1  combinational; issue is blocked this cycle.
- wb_valid  in  1  writeback stage holds a valid instruction.
- wb_we  in  1  writeback instruction commits a register write.
- wb_addr  in  5  writeback destination register.
- flush  in  1  discard all in-flight instructions (exception or redirect).
- pending  out  NREG  bit i = 1 when count[i] != 0; bit 0 is always 0.
- err  out  1  sticky error flag: a writeback retired to a register whose count was 0.

## Operation
- Each register 1..31 has an unsigned counter count[i] of CNT_W bits. Register 0 has no counter.
- stall = issue_valid && (A || B || C), where:
  - A: rs_used && rs_addr != 0 && count[rs_addr] != 0
  - B: rt_used && rt_addr != 0 && count[rt_addr] != 0
  - C: issue_we && issue_waddr != 0 && count[issue_waddr] == max
- Issue is accepted when issue_valid && !stall. If also issue_we && issue_waddr != 0, count[issue_waddr] increments.
- Retire: wb_valid && wb_we && wb_addr != 0.
  - If count[wb_addr] != 0, it decrements.
  - If count[wb_addr] == 0, the count is unchanged and err is set.
- An accept and a retire on the same register in the same cycle produce no net change, even at count 0 or at max. Such a pair never sets err.
- flush: all counts go to 0 next cycle. Issue and retire in the flush cycle are ignored. err is unchanged by flush.
- reset has priority over flush. It clears all counts and err.

## Timing
- Reset values: all counts 0, pending = 0, err = 0. stall = 0 while counts are 0.
- stall is combinational from the registered counts and the current inputs. It has no dependence on same-cycle wb_* signals: a retire releases a stall on the following cycle, never in the same cycle. This matches the register file, which has no internal write-to-read bypass.
- Counter updates, pending and err take effect one cycle after the triggering edge inputs.
- Counters never wrap.
  - Increment at max is impossible because condition C blocks it.
  - Decrement below 0 is blocked and reported through err.

## Structure
- Shared package: NREG, CNT_W, REG_ADDR_W = 5, REG_ZERO = 5'd0.
- Sub-module sb_counter: one per-register saturating up/down counter with inputs inc, dec and clr, and outputs cnt, nonzero, full and underflow. Instantiate it 31 times with a generate loop.
- The top level holds the stall decode, the address one-hot decode and the err register.

## Test plan
- Issue with we to $8, then hold rs_addr=8 with rs_used=1 → stall=1 and pending[8]=1. Retire $8 in cycle N → stall stays 1 in cycle N and drops to 0 in N+1.
- Issue with we to $0 five times, then use rs=$0 and rt=$0 → pending=0 and stall=0 throughout.
- Three accepted issues to $9 → count 3. A fourth issue_we to $9 with no source used → stall=1. One retire of $9 → the fourth issue is accepted the next cycle.
- count[10]=1, then same-cycle accept of a write to $10 and retire of $10 → count stays 1, pending[10] stays 1, err=0.
- Retire to $11 with count 0 → err=1 next cycle and stays 1. A later flush leaves err=1; reset clears it.
- Pending on $3 and $4, then flush together with an issue to $5 and a retire of $3 → next cycle pending=0 and count[5]=0.
